um_mem_arb_mc: RTL and testbench

- Multi-core successor of the single-core user-module memory path.
- Arbitrates memory requests from NUM_CORES in-line RISC-V cores onto the single packet-pipeline memory port, round-robin.
- Returns read data to the requesting core.
- Sits between the TuMan32 core instances and the pipeline memory interface; per-core enables come from the configuration logic (cores under configuration are masked).

---
 rtl/um_mem_arb_mc.sv | 112 +++++++++++
 tb/tb_um_mem_arb_mc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/um_mem_arb_mc.sv
// Round-robin arbiter that funnels NUM_CORES core memory ports onto one pipeline port,
// with a fixed-latency tag pipeline that routes read data back to the issuing core.
module um_mem_arb_mc #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CORES-1:0]    core_en,
   input  logic [NUM_CORES-1:0]    core_mem_wren,
   input  logic [NUM_CORES-1:0]    core_mem_rden,
   input  logic [NUM_CORES*AW-1:0] core_mem_addr,
   input  logic [NUM_CORES*DW-1:0] core_mem_wdata,
   output logic [NUM_CORES-1:0]    core_mem_gnt,
   output logic [NUM_CORES-1:0]    core_mem_rvalid,
   output logic [DW-1:0]           core_mem_rdata,
   input  logic                    mem_ready,
   output logic                    mem_wren,
   output logic                    mem_rden,
   output logic [AW-1:0]           mem_addr,
   output logic [DW-1:0]           mem_wdata,
   input  logic [DW-1:0]           mem_rdata,
   output logic [NUM_CORES-1:0]    core_ready
);

   localparam int unsigned IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_CORES - 1);

   logic [NUM_CORES-1:0] elig;
   logic [IDW-1:0]       ptr;
   logic [IDW-1:0]       win;
   logic [IDW-1:0]       cand;
   logic                 found;
   logic                 grant;
   int unsigned          idx;

   logic [IDW-1:0]       iss_id;
   logic [RD_LAT-1:0]    trk_vld;
   logic [IDW-1:0]       trk_id [RD_LAT];

   // Search starts at ptr and wraps, so the last-served core has lowest priority next.
   always_comb begin
      elig  = core_en & (core_mem_wren | core_mem_rden);
      found = 1'b0;
      win   = '0;
      cand  = '0;
      idx   = 0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         idx  = (32'(ptr) + i) % NUM_CORES;
         cand = IDW'(idx);
         if (!found && elig[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      core_mem_gnt = '0;
      if (!rst && mem_ready && found) begin
         core_mem_gnt[win] = 1'b1;
      end
      grant = |core_mem_gnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr             <= '0;
         mem_wren        <= 1'b0;
         mem_rden        <= 1'b0;
         mem_addr        <= '0;
         mem_wdata       <= '0;
         iss_id          <= '0;
         trk_vld         <= '0;
         core_mem_rvalid <= '0;
         core_mem_rdata  <= '0;
         core_ready      <= '0;
         for (int unsigned j = 0; j < RD_LAT; j++) begin
            trk_id[j] <= '0;
         end
      end else begin
         core_ready <= core_en;

         // A combined write+read request is consumed as a write only.
         mem_wren <= grant & core_mem_wren[win];
         mem_rden <= grant & core_mem_rden[win] & ~core_mem_wren[win];
         if (grant) begin
            mem_addr  <= core_mem_addr[win*AW +: AW];
            mem_wdata <= core_mem_wdata[win*DW +: DW];
            iss_id    <= win;
            ptr       <= (win == LAST_ID) ? '0 : win + 1'b1;
         end

         // Tag pipeline is aligned so its tail is valid in the cycle mem_rdata is valid.
         trk_vld[0] <= mem_rden;
         trk_id[0]  <= iss_id;
         for (int unsigned j = 1; j < RD_LAT; j++) begin
            trk_vld[j] <= trk_vld[j-1];
            trk_id[j]  <= trk_id[j-1];
         end

         core_mem_rvalid <= '0;
         if (trk_vld[RD_LAT-1]) begin
            core_mem_rvalid[trk_id[RD_LAT-1]] <= 1'b1;
            core_mem_rdata                    <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_um_mem_arb_mc.sv
// Bench for um_mem_arb_mc: cycle model of arbitration/issue plus a read-return scoreboard,
// with a fixed-latency memory responder.
module tb_um_mem_arb_mc;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned RL = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      core_en, wr, rd;
   logic [AW-1:0]     addr_a [N];
   logic [DW-1:0]     wd_a   [N];
   logic [N*AW-1:0]   core_mem_addr;
   logic [N*DW-1:0]   core_mem_wdata;
   logic [N-1:0]      core_mem_gnt, core_mem_rvalid, core_ready;
   logic [DW-1:0]     core_mem_rdata;
   logic              mem_ready, mem_wren, mem_rden;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   always_comb begin
      core_mem_addr  = '0;
      core_mem_wdata = '0;
      for (int i = 0; i < N; i++) begin
         core_mem_addr[i*AW +: AW]  = addr_a[i];
         core_mem_wdata[i*DW +: DW] = wd_a[i];
      end
   end

   um_mem_arb_mc #(.NUM_CORES(N), .AW(AW), .DW(DW), .RD_LAT(RL)) dut (
      .clk             (clk),
      .rst             (rst),
      .core_en         (core_en),
      .core_mem_wren   (wr),
      .core_mem_rden   (rd),
      .core_mem_addr   (core_mem_addr),
      .core_mem_wdata  (core_mem_wdata),
      .core_mem_gnt    (core_mem_gnt),
      .core_mem_rvalid (core_mem_rvalid),
      .core_mem_rdata  (core_mem_rdata),
      .mem_ready       (mem_ready),
      .mem_wren        (mem_wren),
      .mem_rden        (mem_rden),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .core_ready      (core_ready)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      if (a == 32'h100) return 32'hDEAD_BEEF;
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   typedef struct {
      int          core;
      logic [DW-1:0] data;
      int          due;
   } rd_t;
   rd_t rq[$];

   // Model state: values the DUT registers should hold in the current cycle.
   int            m_ptr = 0;
   logic          m_wr = 0, m_rd = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wd = '0, m_rdata = '0;
   logic [N-1:0]  m_rdy = '0, m_rv = '0;
   bit            armed = 0;

   logic          pv [RL+1];
   logic [AW-1:0] pa [RL+1];

   initial begin
      logic [N-1:0] elig, eg;
      int           k;
      for (int i = 0; i <= RL; i++) begin
         pv[i] = 1'b0;
         pa[i] = '0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         // Memory responder: data for a read issued in cycle c is presented in cycle c+RL.
         for (int i = RL; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
         end
         pv[0] = mem_rden;
         pa[0] = mem_addr;
         mem_rdata = (pv[RL] === 1'b1) ? mem_f(pa[RL]) : DW'($urandom());

         elig = core_en & (wr | rd);
         k = -1;
         for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (k < 0 && elig[j]) k = j;
         end
         eg = '0;
         if (!rst && mem_ready && k >= 0) eg[k] = 1'b1;

         if (armed) begin
            check_eq("gnt", 64'(core_mem_gnt), 64'(eg));
            check_eq("mem_wren", 64'(mem_wren), 64'(m_wr));
            check_eq("mem_rden", 64'(mem_rden), 64'(m_rd));
            check_eq("mem_addr", 64'(mem_addr), 64'(m_addr));
            check_eq("mem_wdata", 64'(mem_wdata), 64'(m_wd));
            check_eq("core_ready", 64'(core_ready), 64'(m_rdy));
            check_eq("rvalid", 64'(core_mem_rvalid), 64'(m_rv));
            if (m_rv != '0) check_eq("rdata", 64'(core_mem_rdata), 64'(m_rdata));
         end

         if (rst) begin
            m_ptr = 0; m_wr = 0; m_rd = 0; m_addr = '0; m_wd = '0;
            m_rdy = '0; m_rv = '0; m_rdata = '0;
            rq.delete();
            armed = 1;
         end else begin
            m_rdy = core_en;
            m_rv  = '0;
            if (rq.size() > 0 && rq[0].due == cyc + 1) begin
               m_rv[rq[0].core] = 1'b1;
               m_rdata = rq[0].data;
               void'(rq.pop_front());
            end
            if (eg != '0) begin
               m_wr   = wr[k];
               m_rd   = rd[k] && !wr[k];
               m_addr = addr_a[k];
               m_wd   = wd_a[k];
               m_ptr  = (k + 1) % N;
               if (m_rd) rq.push_back('{core: k, data: mem_f(addr_a[k]), due: cyc + RL + 2});
            end else begin
               m_wr = 0;
               m_rd = 0;
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; core_en = '1; wr = '0; rd = '0; mem_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         addr_a[i] = AW'(32'h1000 * (i + 1));
         wd_a[i]   = DW'(32'hC0DE_0000 + i);
      end
      step(3);
      rst = 1'b0;
      step(2);

      // Reset while a read is in flight: dropped, pointer back to 0.
      rd[1] = 1'b1; addr_a[1] = 32'h40;
      step();
      rd = '0; rst = 1'b1;
      step();
      rst = 1'b0;
      step(2);
      wr = '1;
      step();
      wr = '0;
      step(6);

      // Single read with known data.
      rd[2] = 1'b1; addr_a[2] = 32'h100;
      step();
      rd = '0;
      step(6);

      // Round-robin with all cores writing.
      wr = '1;
      step(10);
      wr = '0;
      step(2);

      // Backpressure then resume at the pointer.
      wr = '1; mem_ready = 1'b0;
      step(5);
      mem_ready = 1'b1;
      step(3);
      wr = '0;
      step(2);

      // Masked core and write-over-read priority.
      core_en[1] = 1'b0; wr = '1;
      step(8);
      wr = '0; core_en = '1;
      wr[3] = 1'b1; rd[3] = 1'b1; addr_a[3] = 32'h300;
      step();
      wr = '0; rd = '0;
      step(6);

      // Alternating back-to-back reads from cores 0 and 3.
      for (int i = 0; i < 12; i++) begin
         int c;
         c = (i % 2) ? 3 : 0;
         rd = '0;
         rd[c] = 1'b1;
         addr_a[c] = AW'(32'h2000 + i * 4);
         step();
      end
      rd = '0;
      step(6);

      // Core disabled while its read is in flight: return still delivered.
      rd[0] = 1'b1; addr_a[0] = 32'h3330;
      step();
      rd = '0; core_en[0] = 1'b0;
      step(6);
      core_en = '1;

      // Random traffic with occasional resets.
      for (int i = 0; i < 300; i++) begin
         core_en   = N'($urandom_range(0, 15)) | N'($urandom_range(0, 15));
         wr        = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
         rd        = N'($urandom_range(0, 15));
         mem_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 99) == 0);
         for (int c = 0; c < N; c++) begin
            addr_a[c] = AW'($urandom());
            wd_a[c]   = DW'($urandom());
         end
         step();
      end
      rst = 1'b0; wr = '0; rd = '0; core_en = '1; mem_ready = 1'b1;
      step(12);
      check_eq("rd_drain", 64'(rq.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
